// File: rtl/seg7_scroll_scan_ctrl_if.sv
// -----------------------------------------------------------------------------
// seg7_scroll_scan_ctrl_if
//   Message-side bus of the 7-segment scroll/scan controller: character
//   writes into the message buffer plus the live length and scroll control.
//
//   wr_en      1  write wr_data into buffer entry wr_addr this cycle
//   wr_addr    4  buffer index to write
//   wr_data    5  character code
//   msg_len    5  active message length (values above 16 behave as 16)
//   scroll_en  1  1 = scroll offset advances at scroll boundaries
//
//   master : user logic that composes the message
//   slave  : the display controller
// -----------------------------------------------------------------------------
interface seg7_scroll_scan_ctrl_if;
   logic       wr_en;
   logic [3:0] wr_addr;
   logic [4:0] wr_data;
   logic [4:0] msg_len;
   logic       scroll_en;

   modport master (output wr_en, wr_addr, wr_data, msg_len, scroll_en);
   modport slave  (input  wr_en, wr_addr, wr_data, msg_len, scroll_en);
endinterface

// File: rtl/seg7_scroll_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg7_scroll_scan_ctrl
//   Digit-multiplexing and scrolling scheduler for the 8-digit common-anode
//   7-segment display. Each digit owns a slot of TICK_DIV cycles; the first
//   BLANK_CYC cycles of a slot keep every anode off so cathodes can change
//   without ghosting. A 16-entry character buffer is scrolled across the
//   digits, one position every SCROLL_FRAMES complete frames.
//
//   clk          system clock
//   rst          synchronous reset, active-high
//   bus          message bus (slave side): writes, length, scroll enable
//   AN[7:0]      anodes, active-low, AN[0] = rightmost digit
//   Ca[7:0]      cathodes, active-low, {dp,g,f,e,d,c,b,a}
//   frame_start  one-cycle pulse as the digit-0 slot begins
// -----------------------------------------------------------------------------
module seg7_scroll_scan_ctrl #(
   parameter int TICK_DIV      = 100000,
   parameter int BLANK_CYC     = 2000,
   parameter int SCROLL_FRAMES = 64,
   parameter int MSG_DEPTH     = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   seg7_scroll_scan_ctrl_if.slave        bus,
   output logic [7:0]                    AN,
   output logic [7:0]                    Ca,
   output logic                          frame_start
);

   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int FR_W  = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);
   localparam logic [FR_W-1:0]  FR_LAST   = FR_W'(SCROLL_FRAMES - 1);
   localparam logic [4:0]       CODE_BLANK = 5'd17;

   typedef enum logic {
      PH_BLANK,
      PH_DRIVE
   } phase_e;

   localparam phase_e PH_RESET = (BLANK_CYC > 0) ? PH_BLANK : PH_DRIVE;

   // Character code -> active-low segment pattern, decimal point always off.
   function automatic logic [7:0] seg7_encode(input logic [4:0] code);
      logic [7:0] seg;
      case (code)
         5'd0:    seg = 8'hC0;
         5'd1:    seg = 8'hF9;
         5'd2:    seg = 8'hA4;
         5'd3:    seg = 8'hB0;
         5'd4:    seg = 8'h99;
         5'd5:    seg = 8'h92;
         5'd6:    seg = 8'h82;
         5'd7:    seg = 8'hF8;
         5'd8:    seg = 8'h80;
         5'd9:    seg = 8'h90;
         5'd10:   seg = 8'h88;
         5'd11:   seg = 8'h83;
         5'd12:   seg = 8'hC6;
         5'd13:   seg = 8'hA1;
         5'd14:   seg = 8'h86;
         5'd15:   seg = 8'h8E;
         5'd16:   seg = 8'hBF;   // '-'
         5'd18:   seg = 8'hAB;   // 'n'
         default: seg = 8'hFF;   // blank
      endcase
      return seg;
   endfunction

   // Scan / scroll state
   phase_e            phase;
   logic [CNT_W-1:0]  cnt;
   logic [2:0]        digit;
   logic [FR_W-1:0]   frame_cnt;
   logic [3:0]        offset;
   logic [4:0]        msg_buf [MSG_DEPTH];

   // Combinational helpers
   logic [CNT_W-1:0]  cnt_next;
   logic              slot_end;
   logic              frame_end;
   logic [4:0]        msg_l;
   logic [2:0]        pos_k;
   logic [4:0]        sum_raw;
   logic [4:0]        sum_w1;
   logic [4:0]        sum_w2;
   logic [4:0]        char_code;

   assign slot_end  = (cnt == CNT_LAST);
   assign frame_end = slot_end && (digit == 3'd7);
   assign cnt_next  = slot_end ? '0 : cnt + 1'b1;

   assign msg_l = (bus.msg_len > 5'd16) ? 5'd16 : bus.msg_len;

   // Digit 7 is the leftmost position (k = 0).
   assign pos_k = ~digit;

   // (offset + k) mod L for L in 9..16: the sum never exceeds 22, so two
   // conditional subtractions cover it even when offset is stale (>= L).
   assign sum_raw = {1'b0, offset} + {2'b00, pos_k};
   assign sum_w1  = (sum_raw >= msg_l) ? sum_raw - msg_l : sum_raw;
   assign sum_w2  = (sum_w1  >= msg_l) ? sum_w1  - msg_l : sum_w1;

   // NOTE: every signal assigned in always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      char_code = CODE_BLANK;
      if (msg_l > 5'd8) begin
         char_code = msg_buf[sum_w2[3:0]];
      end else if ({2'b00, pos_k} < msg_l) begin
         char_code = msg_buf[{1'b0, pos_k}];
      end
   end

   // NOTE: state and registered outputs use non-blocking assignments so every
   // register samples the pre-edge values of its sources.
   always_ff @(posedge clk) begin
      if (rst) begin
         phase       <= PH_RESET;
         cnt         <= '0;
         digit       <= '0;
         frame_cnt   <= '0;
         offset      <= '0;
         AN          <= 8'hFF;
         Ca          <= 8'hFF;
         frame_start <= 1'b0;
         // NOTE: the message buffer is reset because a freshly reset display
         // must show blanks, not whatever the flops powered up with.
         for (int i = 0; i < MSG_DEPTH; i++) begin
            msg_buf[i] <= CODE_BLANK;
         end
      end else begin
         // A write lands at this edge; the outputs below still use the old
         // entry because char_code was formed from pre-edge buffer contents.
         if (bus.wr_en) begin
            msg_buf[bus.wr_addr] <= bus.wr_data;
         end

         cnt   <= cnt_next;
         phase <= (cnt_next < BLANK_END) ? PH_BLANK : PH_DRIVE;

         if (slot_end) begin
            digit <= digit + 3'd1;
         end

         if (frame_end) begin
            frame_cnt <= (frame_cnt == FR_LAST) ? '0 : frame_cnt + 1'b1;
            // Short or shrunken messages pull the offset back to the start;
            // otherwise it only moves on a scroll boundary.
            if (msg_l <= 5'd8 || {1'b0, offset} >= msg_l) begin
               offset <= '0;
            end else if (frame_cnt == FR_LAST && bus.scroll_en) begin
               offset <= ({1'b0, offset} + 5'd1 == msg_l) ? 4'd0 : offset + 4'd1;
            end
         end

         // Outputs reflect this cycle's slot position.
         frame_start <= (cnt == '0) && (digit == 3'd0);
         if (phase == PH_BLANK) begin
            AN <= 8'hFF;
            Ca <= 8'hFF;
         end else begin
            AN <= ~(8'h01 << digit);
            Ca <= seg7_encode(char_code);
         end
      end
   end

endmodule
